// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache and its neighbours (fetch,
// decode, ROB): boolean constants, refill FSM encoding and default geometry.
package icache_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int DEF_LINE_NUM   = 64;
    localparam int DEF_LINE_WORDS = 4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_array.sv
// Tag, valid and data storage of the direct-mapped instruction cache.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset (valid bits only)
//   rd_index/rd_offset/rd_tag combinational lookup address
//   rd_hit, rd_inst           lookup result (rd_inst don't-care on miss)
//   inv_en, inv_index         clear the valid bit of one line
//   wr_en, wr_index, wr_tag,  write a complete line and mark it valid
//   wr_line
module icache_array
    import icache_pkg::*;
#(
    parameter int LINE_NUM   = DEF_LINE_NUM,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int IDX_W      = $clog2(LINE_NUM),
    parameter int OFF_W      = $clog2(LINE_WORDS),
    parameter int TAG_W      = 30 - IDX_W - OFF_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [IDX_W-1:0]           rd_index,
    input  logic [OFF_W-1:0]           rd_offset,
    input  logic [TAG_W-1:0]           rd_tag,
    output logic                       rd_hit,
    output logic [31:0]                rd_inst,
    input  logic                       inv_en,
    input  logic [IDX_W-1:0]           inv_index,
    input  logic                       wr_en,
    input  logic [IDX_W-1:0]           wr_index,
    input  logic [TAG_W-1:0]           wr_tag,
    input  logic [LINE_WORDS*32-1:0]   wr_line
);

    logic [LINE_NUM-1:0]         valid_r;
    logic [TAG_W-1:0]            tag_r  [LINE_NUM];
    logic [LINE_WORDS*32-1:0]    data_r [LINE_NUM];

    // Combinational read port; the valid bit masks uninitialised tags.
    always_comb begin
        rd_hit  = valid_r[rd_index] && (tag_r[rd_index] == rd_tag);
        rd_inst = data_r[rd_index][32*rd_offset +: 32];
    end

    // Valid bits: cleared on reset and when a refill claims the line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= '0;
        end else if (wr_en) begin
            valid_r[wr_index] <= TRUE;
        end else if (inv_en) begin
            valid_r[inv_index] <= FALSE;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag and data storage; no reset, validity is carried by valid_r.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_r[wr_index]  <= wr_tag;
            data_r[wr_index] <= wr_line;
        end
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with a word-serial refill FSM.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   rdy               global ready; low freezes all state
//   pc                fetch address
//   icache_hit        combinational hit for pc
//   icache_inst       instruction at pc (valid when icache_hit)
//   mem_inst_req      registered word-read request
//   mem_inst_addr     registered word address of the request
//   mem_inst_done     one-cycle pulse: word returned
//   mem_inst_data     returned word
module icache
    import icache_pkg::*;
#(
    parameter int LINE_NUM   = DEF_LINE_NUM,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] pc,
    output logic        icache_hit,
    output logic [31:0] icache_inst,
    output logic        mem_inst_req,
    output logic [31:0] mem_inst_addr,
    input  logic        mem_inst_done,
    input  logic [31:0] mem_inst_data
);

    localparam int OFF_W   = $clog2(LINE_WORDS);
    localparam int IDX_W   = $clog2(LINE_NUM);
    localparam int TAG_W   = 30 - IDX_W - OFF_W;
    localparam int OFF_MSB = OFF_W + 1;
    localparam logic [OFF_W-1:0] K_LAST = OFF_W'(LINE_WORDS - 1);
    localparam logic [OFF_W-1:0] K_ONE  = OFF_W'(1);

    icache_state_t             state_r;
    logic [OFF_W-1:0]          k_r;
    logic [30-OFF_W:0]         line_hi_r;   // {tag, index} of the line being refilled
    logic [LINE_WORDS*32-1:0]  buf_r;

    logic [OFF_W-1:0]          pc_offset_s;
    logic [IDX_W-1:0]          pc_index_s;
    logic [TAG_W-1:0]          pc_tag_s;
    logic [OFF_W-1:0]          k_next_s;
    logic                      start_s;
    logic                      last_s;
    logic [LINE_WORDS*32-1:0]  wr_line_s;

    // Address split and FSM strobes.
    always_comb begin
        pc_offset_s = pc[OFF_MSB:2];
        pc_index_s  = pc[OFF_MSB+IDX_W:OFF_MSB+1];
        pc_tag_s    = pc[31:OFF_MSB+IDX_W+1];
        k_next_s    = k_r + K_ONE;
        start_s     = (state_r == IDLE) && rdy && !icache_hit;
        last_s      = (state_r == REFILL) && rdy && mem_inst_done && (k_r == K_LAST);
    end

    // Final line image: the buffered words plus the word arriving this cycle.
    always_comb begin
        wr_line_s = buf_r;
        wr_line_s[32*k_r +: 32] = mem_inst_data;
    end

    icache_array #(
        .LINE_NUM   (LINE_NUM),
        .LINE_WORDS (LINE_WORDS)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .rd_index   (pc_index_s),
        .rd_offset  (pc_offset_s),
        .rd_tag     (pc_tag_s),
        .rd_hit     (icache_hit),
        .rd_inst    (icache_inst),
        .inv_en     (start_s),
        .inv_index  (pc_index_s),
        .wr_en      (last_s),
        .wr_index   (line_hi_r[IDX_W-1:0]),
        .wr_tag     (line_hi_r[30-OFF_W:IDX_W]),
        .wr_line    (wr_line_s)
    );

    // Refill FSM: latches the missing line, walks its words, holds on !rdy.
    // A pc change during REFILL is deliberately ignored until IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= IDLE;
            k_r           <= '0;
            line_hi_r     <= '0;
            buf_r         <= '0;
            mem_inst_req  <= FALSE;
            mem_inst_addr <= 32'h0000_0000;
        end else if (rdy) begin
            case (state_r)
                IDLE: begin
                    if (!icache_hit) begin
                        state_r       <= REFILL;
                        k_r           <= '0;
                        line_hi_r     <= pc[31:OFF_MSB+1];
                        mem_inst_req  <= TRUE;
                        mem_inst_addr <= {pc[31:OFF_MSB+1], {(OFF_W+2){1'b0}}};
                    end else begin
                        mem_inst_req  <= FALSE;
                    end
                end
                REFILL: begin
                    if (mem_inst_done) begin
                        buf_r[32*k_r +: 32] <= mem_inst_data;
                        if (k_r == K_LAST) begin
                            state_r      <= IDLE;
                            k_r          <= '0;
                            mem_inst_req <= FALSE;
                        end else begin
                            k_r           <= k_next_s;
                            mem_inst_addr <= {line_hi_r, k_next_s, 2'b00};
                        end
                    end else begin
                        mem_inst_req <= TRUE;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    k_r          <= '0;
                    mem_inst_req <= FALSE;
                end
            endcase
        end else begin
            mem_inst_req <= mem_inst_req;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: expected refill addresses are queued by the
// stimulus and popped by a monitor on every accepted memory transaction.
module tb_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [31:0] pc;
    logic        icache_hit;
    logic [31:0] icache_inst;
    logic        mem_inst_req;
    logic [31:0] mem_inst_addr;
    logic        mem_inst_done;
    logic [31:0] mem_inst_data;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    icache dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .pc            (pc),
        .icache_hit    (icache_hit),
        .icache_inst   (icache_inst),
        .mem_inst_req  (mem_inst_req),
        .mem_inst_addr (mem_inst_addr),
        .mem_inst_done (mem_inst_done),
        .mem_inst_data (mem_inst_data)
    );

    always #5 clk = ~clk;

    // Memory contents: a distinct word per address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ (a << 4) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_line(input logic [31:0] base);
        for (int i = 0; i < 4; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    // Memory responder for one word: wait for the request, one wait state, pulse done.
    task automatic serve_word();
        int n = 0;
        while (!mem_inst_req && n < 20) begin
            tick();
            n++;
        end
        if (!mem_inst_req) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got req=0 expected req=1 within 20 cycles");
        end else begin
            tick();
            mem_inst_data = mem_word(mem_inst_addr);
            mem_inst_done = 1'b1;
            tick();
            mem_inst_done = 1'b0;
            mem_inst_data = 32'h0000_0000;
        end
    endtask

    // Monitor: every transaction the DUT accepts must match the queue head.
    always @(negedge clk) begin
        if (rst && rdy && mem_inst_done && mem_inst_req) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL req_addr: got %h expected no request", mem_inst_addr);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (mem_inst_addr !== e) begin
                    errors++;
                    $display("FAIL req_addr: got %h expected %h", mem_inst_addr, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; rdy = 1'b1; pc = 32'h0; mem_inst_done = 1'b0; mem_inst_data = 32'h0;
        tick(); tick();
        check("reset_hit", {31'd0, icache_hit}, 32'd0);
        check("reset_req", {31'd0, mem_inst_req}, 32'd0);
        check("reset_addr", mem_inst_addr, 32'h0);
        rst = 1'b1;

        // Cold miss on line 0
        check("cold_hit", {31'd0, icache_hit}, 32'd0);
        push_line(32'h0000_0000);
        for (int i = 0; i < 4; i++) serve_word();
        check("cold_fill_hit", {31'd0, icache_hit}, 32'd1);
        check("cold_fill_inst", icache_inst, mem_word(32'h0));
        check("cold_req_drop", {31'd0, mem_inst_req}, 32'd0);

        // Hit path
        pc = 32'h0000_0008;
        #1;
        check("hit_word2", icache_inst, mem_word(32'h8));
        check("hit_flag", {31'd0, icache_hit}, 32'd1);
        tick(); tick();
        check("hit_no_req", {31'd0, mem_inst_req}, 32'd0);

        // done outside REFILL is ignored
        mem_inst_data = 32'hDEAD_BEEF; mem_inst_done = 1'b1;
        tick();
        mem_inst_done = 1'b0;
        tick();
        check("idle_done_req", {31'd0, mem_inst_req}, 32'd0);
        check("idle_done_inst", icache_inst, mem_word(32'h8));

        // Conflict eviction at index 0
        pc = 32'h0000_0400;
        #1;
        check("evict_miss", {31'd0, icache_hit}, 32'd0);
        push_line(32'h0000_0400);
        for (int i = 0; i < 4; i++) serve_word();
        check("evict_fill_inst", icache_inst, mem_word(32'h400));
        pc = 32'h0000_0000;
        #1;
        check("evicted_old", {31'd0, icache_hit}, 32'd0);
        push_line(32'h0000_0000);
        for (int i = 0; i < 4; i++) serve_word();
        check("refill0_inst", icache_inst, mem_word(32'h0));

        // pc change mid-refill
        pc = 32'h0000_0100;
        push_line(32'h0000_0100);
        serve_word(); serve_word();
        pc = 32'h0000_0200;
        serve_word(); serve_word();
        #1;
        check("redirect_miss", {31'd0, icache_hit}, 32'd0);
        push_line(32'h0000_0200);
        for (int i = 0; i < 4; i++) serve_word();
        pc = 32'h0000_020C;
        #1;
        check("redirect_fill_inst", icache_inst, mem_word(32'h20C));
        pc = 32'h0000_0104;
        #1;
        check("completed_line_hit", {31'd0, icache_hit}, 32'd1);
        check("completed_line_inst", icache_inst, mem_word(32'h104));

        // Reset mid-refill
        pc = 32'h0000_0300;
        push_line(32'h0000_0300);
        serve_word(); serve_word();
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_req", {31'd0, mem_inst_req}, 32'd0);
        check("async_rst_addr", mem_inst_addr, 32'h0);
        exp_q.delete();
        pc = 32'h0000_0100;
        #1;
        check("rst_cleared_valid", {31'd0, icache_hit}, 32'd0);
        tick();
        rdy = 1'b0;
        rst = 1'b1;
        tick(); tick();
        check("rst_release_rdy0_req", {31'd0, mem_inst_req}, 32'd0);
        rdy = 1'b1;
        push_line(32'h0000_0100);
        for (int i = 0; i < 4; i++) serve_word();
        check("restart_inst", icache_inst, mem_word(32'h100));

        // rdy stall with spurious done pulses
        pc = 32'h0000_0500;
        push_line(32'h0000_0500);
        serve_word();
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_inst_done = 1'b1;
            mem_inst_data = 32'hBAD0_0000 + 32'(i);
            tick();
            check("stall_addr", mem_inst_addr, 32'h0000_0504);
            check("stall_req", {31'd0, mem_inst_req}, 32'd1);
        end
        mem_inst_done = 1'b0;
        mem_inst_data = 32'h0;
        rdy = 1'b1;
        for (int i = 0; i < 3; i++) serve_word();
        pc = 32'h0000_0504;
        #1;
        check("stall_fill_hit", {31'd0, icache_hit}, 32'd1);
        check("stall_fill_inst", icache_inst, mem_word(32'h504));
        pc = 32'h0000_050C;
        #1;
        check("stall_fill_last", icache_inst, mem_word(32'h50C));

        tick(); tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
